// File: rtl/freq_meas_ctrl.sv
// Frequency meter measurement sequencer.
// Opens a gate of GATE_TICKS timebase ticks, counts synchronized rising edges
// of sig_in in BCD during the gate, latches the count for the display when the
// gate closes, then clears and waits for the next tick to start again.
// Everything runs on sysclk; sig_in is the only asynchronous input.

module freq_meas_ctrl #(
  parameter int DIGITS      = 6,
  parameter int GATE_TICKS  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  tick,
  input  logic                  sig_in,
  output logic                  gate_open,
  output logic [4*DIGITS-1:0]   result,
  output logic                  overflow,
  output logic                  result_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GATE  = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  localparam int            TW        = (GATE_TICKS > 1) ? $clog2(GATE_TICKS) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(GATE_TICKS - 1);

  logic [1:0]             state;
  logic [1:0]             state_next;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sig_edge;

  logic [4*DIGITS-1:0]    count_q;
  logic [4*DIGITS-1:0]    count_inc;
  logic [4*DIGITS-1:0]    count_next;
  logic                   all_nines;
  logic                   bcd_carry;
  logic                   ovf_q;
  logic                   ovf_next;
  logic [TW-1:0]          tick_cnt;

  logic                   closing;

  // Synchronize sig_in and keep one extra flop to detect the rising edge.
  // NOTE: every sequential block uses non-blocking assignments so all flops
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  // BCD increment: ripple a carry from digit0 upwards in a single cycle.
  // NOTE: combinational blocks assign a default to every output first so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    count_inc = count_q;
    bcd_carry = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count_q[4*i +: 4] != 4'd9) begin
        all_nines = 1'b0;
      end
      if (bcd_carry) begin
        if (count_q[4*i +: 4] >= 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          bcd_carry           = 1'b0;
        end
      end
    end
  end

  // Value of count/flag after this cycle's edge (saturates at all nines).
  always_comb begin
    count_next = count_q;
    ovf_next   = ovf_q;
    if (sig_edge) begin
      if (all_nines) begin
        ovf_next = 1'b1;
      end else begin
        count_next = count_inc;
      end
    end
  end

  // Closing tick ends the gate; a dropped start wins over it (abort).
  assign closing = (state == S_GATE) && start && tick && (tick_cnt == LAST_TICK);

  // Next-state logic for the IDLE -> GATE -> LATCH -> CLEAR loop.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start && tick) begin
          state_next = S_GATE;
        end
      end
      S_GATE: begin
        if (!start) begin
          state_next = S_IDLE;
        end else if (closing) begin
          state_next = S_LATCH;
        end
      end
      S_LATCH: state_next = S_CLEAR;
      S_CLEAR: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Edge counter, sticky saturation flag and gate tick counter.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      count_q  <= '0;
      ovf_q    <= 1'b0;
      tick_cnt <= '0;
    end else begin
      case (state)
        S_GATE: begin
          if (!start) begin
            count_q  <= '0;
            ovf_q    <= 1'b0;
            tick_cnt <= '0;
          end else begin
            count_q  <= count_next;
            ovf_q    <= ovf_next;
            if (tick) begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_LATCH: begin
          // Edges are ignored while the result is being handed over.
          count_q  <= count_q;
          ovf_q    <= ovf_q;
          tick_cnt <= tick_cnt;
        end
        default: begin
          count_q  <= '0;
          ovf_q    <= 1'b0;
          tick_cnt <= '0;
        end
      endcase
    end
  end

  // Capture on the transition into LATCH, including an edge on the closing
  // cycle, so result_valid is high exactly while state == LATCH.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      result       <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= closing;
      if (closing) begin
        result   <= count_next;
        overflow <= ovf_next;
      end
    end
  end

  assign gate_open = (state == S_GATE);

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Randomized bench for freq_meas_ctrl. Two instances share stimulus: one with
// default parameters and one small-counter, multi-tick, 3-stage-sync variant.
// A cycle-level reference model tracks gate windows with plain integer edge
// counts and converts to saturated BCD only when a result is produced.

module tb_freq_meas_ctrl;

  localparam int TICK_P = 200;
  localparam int NCYC   = 40000;

  localparam int A_D = 6, A_G = 1, A_S = 2;
  localparam int B_D = 2, B_G = 3, B_S = 3;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  logic start  = 1'b0;
  logic tick   = 1'b0;
  logic sig_in = 1'b0;

  logic              gate_a, ovf_a, valid_a;
  logic [4*A_D-1:0]  res_a;
  logic              gate_b, ovf_b, valid_b;
  logic [4*B_D-1:0]  res_b;

  freq_meas_ctrl #(.DIGITS(A_D), .GATE_TICKS(A_G), .SYNC_STAGES(A_S)) dut_a (
    .sysclk(sysclk), .rst_n(rst_n), .start(start), .tick(tick), .sig_in(sig_in),
    .gate_open(gate_a), .result(res_a), .overflow(ovf_a), .result_valid(valid_a)
  );

  freq_meas_ctrl #(.DIGITS(B_D), .GATE_TICKS(B_G), .SYNC_STAGES(B_S)) dut_b (
    .sysclk(sysclk), .rst_n(rst_n), .start(start), .tick(tick), .sig_in(sig_in),
    .gate_open(gate_b), .result(res_b), .overflow(ovf_b), .result_valid(valid_b)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, one slot per instance.
  int unsigned m_edges [2];
  int unsigned m_ticks [2];
  int unsigned m_block [2];
  bit          m_gating[2];
  bit          m_valid [2];
  bit          m_ovf   [2];
  logic [31:0] m_result[2];
  bit   [7:0]  m_hist  [2];

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // One sysclk step: an input rise sampled at posedge n counts at posedge n+s.
  task automatic model_step(input int k, input int d, input int g, input int s);
    bit          e;
    int unsigned maxv;
    maxv = 1;
    for (int i = 0; i < d; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    if (!rst_n) begin
      m_edges[k] = 0; m_ticks[k] = 0; m_block[k] = 0;
      m_gating[k] = 0; m_valid[k] = 0; m_ovf[k] = 0;
      m_result[k] = '0; m_hist[k] = '0;
      return;
    end
    e = m_hist[k][s-1] & ~m_hist[k][s];
    m_hist[k] = {m_hist[k][6:0], sig_in};
    m_valid[k] = 0;
    if (m_block[k] > 0) begin
      m_block[k]--;
    end else if (m_gating[k]) begin
      if (!start) begin
        m_gating[k] = 0;
        m_edges[k]  = 0;
      end else begin
        if (e) m_edges[k]++;
        if (tick) begin
          m_ticks[k]++;
          if (m_ticks[k] == g) begin
            m_gating[k] = 0;
            m_valid[k]  = 1;
            m_ovf[k]    = (m_edges[k] > maxv);
            m_result[k] = to_bcd((m_edges[k] > maxv) ? maxv : m_edges[k]);
            m_block[k]  = 2;
          end
        end
      end
    end else if (start && tick) begin
      m_gating[k] = 1;
      m_ticks[k]  = 0;
      m_edges[k]  = 0;
    end
  endtask

  always @(posedge sysclk) begin
    model_step(0, A_D, A_G, A_S);
    model_step(1, B_D, B_G, B_S);
  end

  bit chk_en = 0;
  int pulses_a = 0, pulses_b = 0, ovf_pulses_b = 0, clean_pulses_b = 0;

  // Compare every output of both instances against the model each cycle.
  always @(negedge sysclk) begin
    if (chk_en) begin
      check("a_gate_open",    {31'd0, gate_a},  {31'd0, m_gating[0]});
      check("a_result_valid", {31'd0, valid_a}, {31'd0, m_valid[0]});
      check("a_result",       {8'd0, res_a},    {8'd0, m_result[0][23:0]});
      check("a_overflow",     {31'd0, ovf_a},   {31'd0, m_ovf[0]});
      check("b_gate_open",    {31'd0, gate_b},  {31'd0, m_gating[1]});
      check("b_result_valid", {31'd0, valid_b}, {31'd0, m_valid[1]});
      check("b_result",       {24'd0, res_b},   {24'd0, m_result[1][7:0]});
      check("b_overflow",     {31'd0, ovf_b},   {31'd0, m_ovf[1]});
      if (valid_a === 1'b1) pulses_a++;
      if (valid_b === 1'b1) begin
        pulses_b++;
        if (ovf_b === 1'b1) ovf_pulses_b++;
        else clean_pulses_b++;
      end
    end
  end

  initial begin
    int hi_len, lo_len, ph, start_hold;
    hi_len = 0; lo_len = 0; ph = 0; start_hold = 50;
    rst_n = 1'b0;
    @(posedge sysclk);
    @(negedge sysclk);
    chk_en = 1;
    check("rst_a_result", {8'd0, res_a}, 32'd0);
    check("rst_b_valid",  {31'd0, valid_b}, 32'd0);
    @(negedge sysclk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge sysclk);
      tick = ((cyc % TICK_P) == TICK_P - 1);
      // Directed fast then slow signal to force saturated and clean results,
      // then random periods.
      if (cyc < 3000) begin
        hi_len = 0; lo_len = 0;
      end else if (cyc < 6000) begin
        hi_len = 9; lo_len = 9;
      end else if (cyc % 1700 == 0) begin
        hi_len = $urandom_range(0, 8);
        lo_len = $urandom_range(0, 8);
      end
      if (ph == 0) begin
        sig_in = ~sig_in;
        ph = sig_in ? hi_len : lo_len;
      end else begin
        ph--;
      end
      rst_n = (cyc < 6000) || ($urandom_range(0, 9999) != 0);
      if (start_hold > 0) start_hold--;
      else if (cyc >= 6000 && $urandom_range(0, 2999) == 0) start_hold = $urandom_range(1, 500);
      start = (start_hold == 0);
    end
    @(negedge sysclk);
    check("a_pulses_seen",      {31'd0, (pulses_a >= 20)},      32'd1);
    check("b_pulses_seen",      {31'd0, (pulses_b >= 5)},       32'd1);
    check("b_overflow_seen",    {31'd0, (ovf_pulses_b >= 1)},   32'd1);
    check("b_clean_result_seen",{31'd0, (clean_pulses_b >= 1)}, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
